adc_frame_scheduler: RTL and testbench

Sequences the per-sample processing chain from the two ADC readers. Both reader ticks must arrive as a pair inside a bounded window. The block then issues a single jitter-free `master_tick_o` a fixed number of cycles after the first tick of the frame; this pulse drives the input filters and the lock-in. It also keeps the frame counter used for host synchronisation, and flags unpaired and overrun frames.

---
 rtl/adc_frame_scheduler.sv | 78 +++++++
 tb/tb_adc_frame_scheduler.sv | 133 +++++++++++++
 2 files changed

// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler: pairs ADC reader ticks and issues a fixed-latency master tick per frame.
module adc_frame_scheduler #(
  parameter int DELAY_CYCLES = 100,
  parameter int PAIR_WINDOW  = 50,
  parameter int COUNT_WIDTH  = 33
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   adc1_tick_i,
  input  logic                   adc2_tick_i,
  input  logic                   clear_flags_i,
  output logic                   master_tick_o,
  output logic                   busy_o,
  output logic [COUNT_WIDTH-1:0] frame_count_o,
  output logic [15:0]            missed_count_o,
  output logic signed [15:0]     skew_o,
  output logic                   unpaired_o,
  output logic                   overrun_o
);
  localparam int CW = $clog2(DELAY_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, WAIT_PAIR, DELAY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic a1_first, a1_first_n;
  logic last, drop, free, start, partner, same, pair, dup, master_n;
  // cnt holds cycles elapsed since the first tick of the frame (T+cnt)
  always_comb begin
    last       = state == DELAY && cnt == CW'(DELAY_CYCLES);
    drop       = state == WAIT_PAIR && cnt == CW'(PAIR_WINDOW + 1);
    free       = state == IDLE || last || drop;
    start      = free && enable_i && (adc1_tick_i || adc2_tick_i);
    partner    = a1_first ? adc2_tick_i : adc1_tick_i;
    same       = a1_first ? adc1_tick_i : adc2_tick_i;
    pair       = state == WAIT_PAIR && !drop && partner;
    dup        = !free && (state == DELAY ? (adc1_tick_i || adc2_tick_i) : same);
    master_n   = cnt == CW'(DELAY_CYCLES - 1) && (state == DELAY || pair);
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    a1_first_n = a1_first;
    if (start) begin
      state_n    = (adc1_tick_i && adc2_tick_i) ? DELAY : WAIT_PAIR;
      cnt_n      = CW'(1);
      a1_first_n = adc1_tick_i;
    end else if (free) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (pair) begin
      state_n = DELAY;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      cnt            <= '0;
      a1_first       <= 1'b0;
      master_tick_o  <= 1'b0;
      busy_o         <= 1'b0;
      frame_count_o  <= '0;
      missed_count_o <= '0;
      skew_o         <= '0;
      unpaired_o     <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      a1_first      <= a1_first_n;
      master_tick_o <= master_n;
      busy_o        <= state_n != IDLE;
      if (master_tick_o) frame_count_o <= frame_count_o + COUNT_WIDTH'(1);
      if (drop && missed_count_o != 16'hffff) missed_count_o <= missed_count_o + 16'd1;
      if (start && adc1_tick_i && adc2_tick_i) skew_o <= '0;
      else if (pair) skew_o <= a1_first ? 16'(cnt) : -16'(cnt);
      unpaired_o <= drop || (unpaired_o && !clear_flags_i);
      overrun_o  <= dup || (overrun_o && !clear_flags_i);
    end
  end
endmodule

// File: tb/tb_adc_frame_scheduler.sv
// tb_adc_frame_scheduler: directed and random stimulus checked against an absolute-time frame model.
module tb_adc_frame_scheduler;
  localparam int D = 100;
  localparam int PW = 50;
  logic clk = 1'b0;
  logic reset_i, enable_i, adc1, adc2, clr;
  logic master_tick, busy, unpaired, overrun;
  logic [32:0] frame_count;
  logic [15:0] missed_count;
  logic signed [15:0] skew;
  int errors = 0;
  int checks = 0;
  int n = 0;
  bit m_act, m_pair, m_first1;
  int m_t0;
  bit e_mt, e_busy, e_un, e_ov;
  logic [32:0] e_fc;
  logic [15:0] e_mc;
  logic signed [15:0] e_sk;

  adc_frame_scheduler #(.DELAY_CYCLES(D), .PAIR_WINDOW(PW), .COUNT_WIDTH(33)) dut (
    .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
    .adc1_tick_i(adc1), .adc2_tick_i(adc2), .clear_flags_i(clr),
    .master_tick_o(master_tick), .busy_o(busy), .frame_count_o(frame_count),
    .missed_count_o(missed_count), .skew_o(skew), .unpaired_o(unpaired), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, got, exp);
    end
  endtask

  // Frame model in absolute cycle numbers: frame opened at m_t0, master at m_t0+D, drop at m_t0+PW+1.
  task automatic model(input bit a1, input bit a2, input bit en, input bit cl, input bit rs);
    bit free, mtn, uns, ovs;
    if (rs) begin
      m_act = 0; e_mt = 0; e_busy = 0; e_fc = '0; e_mc = '0; e_sk = '0; e_un = 0; e_ov = 0;
      return;
    end
    mtn = 0; uns = 0; ovs = 0;
    e_fc = e_fc + 33'(e_mt);
    free = !m_act || (m_pair && n == m_t0 + D) || (!m_pair && n == m_t0 + PW + 1);
    if (m_act && !free) begin
      if (!m_pair) begin
        if (m_first1 ? a1 : a2) ovs = 1;
        if (m_first1 ? a2 : a1) begin
          m_pair = 1;
          e_sk = m_first1 ? 16'(n - m_t0) : 16'(m_t0 - n);
        end
      end else if (a1 || a2) ovs = 1;
      if (m_pair && n == m_t0 + D - 1) mtn = 1;
    end
    if (m_act && !m_pair && n == m_t0 + PW + 1) begin
      if (e_mc != 16'hffff) e_mc = e_mc + 16'd1;
      uns = 1;
    end
    if (free) begin
      m_act = 0;
      if (en && (a1 || a2)) begin
        m_act = 1; m_t0 = n; m_first1 = a1; m_pair = a1 && a2;
        if (m_pair) e_sk = '0;
      end
    end
    e_busy = m_act;
    e_un = uns || (e_un && !cl);
    e_ov = ovs || (e_ov && !cl);
    e_mt = mtn;
  endtask

  task automatic cyc(input bit a1, input bit a2, input bit en = 1, input bit cl = 0, input bit rs = 0);
    adc1 = a1; adc2 = a2; enable_i = en; clr = cl; reset_i = rs;
    @(posedge clk);
    #1;
    model(a1, a2, en, cl, rs);
    n++;
    chk("master_tick", 64'(master_tick), 64'(e_mt));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("frame_count", 64'(frame_count), 64'(e_fc));
    chk("missed_count", 64'(missed_count), 64'(e_mc));
    chk("skew", 64'(skew), 64'(e_sk));
    chk("unpaired", 64'(unpaired), 64'(e_un));
    chk("overrun", 64'(overrun), 64'(e_ov));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0);
  endtask

  initial begin
    int mode, sk, rate;
    bit a1, a2, en, cl, rs;
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    idle(10);
    cyc(1, 1); idle(110);
    cyc(1, 0); idle(6); cyc(0, 1); idle(100);
    cyc(0, 1); idle(6); cyc(1, 0); idle(100);
    cyc(1, 0); idle(59); cyc(0, 1); idle(120);
    for (int f = 0; f < 50; f++) begin
      cyc(1, 1);
      for (int i = 1; i < D; i++) cyc(f == 7 && i == 40, 0);
    end
    idle(5);
    cyc(1, 1); idle(49); cyc(0, 0, 1, 0, 1); idle(9); cyc(1, 1); idle(105);
    cyc(1, 1, 0); idle(110);
    cyc(0, 0, 1, 1); idle(3);
    cyc(1, 1); idle(5); cyc(1, 0, 1, 1); idle(3); cyc(0, 0, 1, 1); idle(100);
    for (int s = 0; s < 30; s++) begin
      mode = $urandom_range(0, 3);
      sk = $urandom_range(0, 60);
      rate = $urandom_range(2, 80);
      for (int i = 0; i < 500; i++) begin
        a1 = ($urandom_range(0, rate) == 0);
        a2 = ($urandom_range(0, rate) == 0);
        if (mode == 3) begin
          a1 = (n % D == 0) || ($urandom_range(0, 400) == 0);
          a2 = (n % D == sk);
        end
        en = (mode == 2) ? $urandom_range(0, 1) == 1 : $urandom_range(0, 200) != 0;
        cl = ($urandom_range(0, 50) == 0);
        rs = ($urandom_range(0, 3000) == 0);
        cyc(a1, a2, en, cl, rs);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
